// File: rtl/nonogram_pkg.sv
// nonogram_pkg: shared queue entry and feeder state types for the option stream.
package nonogram_pkg;
  localparam int Q_SIZE = 3;
  typedef struct packed {logic hdr; logic [Q_SIZE-1:0] data;} q_entry_t;
  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT_KEEP, DONE} feeder_state_t;
endpackage

// File: rtl/option_ring.sv
// option_ring: circular FIFO with combinational head, push/pop in the same cycle keeps occupancy.
module option_ring #(
  parameter int W = 4,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  assign head = mem[rd_ptr];
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
    assert (!(push && full && !pop));
  end
endmodule

// File: rtl/option_feeder.sv
// option_feeder: issues the line/option queue to the solver, re-appends survivors and
// detects completion by solver report or by a pass that removed nothing.
module option_feeder import nonogram_pkg::*; #(
  parameter int SIZE = 3,
  parameter int DEPTH = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load_valid,
  input  logic [SIZE-1:0]        load_data,
  input  logic                   load_hdr,
  output logic                   load_ready,
  input  logic                   load_done,
  output logic                   out_valid,
  output logic [SIZE-1:0]        out_data,
  output logic                   out_hdr,
  input  logic                   out_ready,
  input  logic                   keep_valid,
  input  logic                   keep,
  input  logic                   solved,
  output logic                   done,
  output logic                   stalled,
  output logic [$clog2(DEPTH):0] entries
);
  localparam int CW = $clog2(DEPTH) + 1;
  feeder_state_t state;
  logic [CW-1:0] pass_len, pass_pos, count, pos_n, end_len;
  logic [SIZE:0] head, push_word;
  logic [SIZE-1:0] opt;
  logic removed, full, empty, push, fire, verdict, hdr_end, pass_end, end_rem;
  option_ring #(.W(SIZE+1), .DEPTH(DEPTH)) u_ring (
    .clk(clk), .rst_n(rst_n), .push(push), .push_data(push_word), .pop(fire),
    .head(head), .full(full), .empty(empty), .count(count)
  );
  assign load_ready = state == LOAD && !full;
  assign out_valid = state == ISSUE && !empty;
  assign out_hdr = out_valid & head[SIZE];
  assign out_data = out_valid ? head[SIZE-1:0] : '0;
  assign done = state == DONE;
  assign entries = count;
  // solved wins over any handshake or verdict in the same cycle
  always_comb begin
    fire = out_valid && out_ready && !solved;
    verdict = state == WAIT_KEEP && keep_valid && !solved;
    push = (load_valid && load_ready) || (fire && head[SIZE]) || (verdict && keep);
    push_word = state == LOAD ? {load_hdr, load_data} : state == ISSUE ? head : {1'b0, opt};
    pos_n = pass_pos + CW'(1);
    hdr_end = fire && head[SIZE] && pos_n == pass_len;
    pass_end = hdr_end || (verdict && pass_pos == pass_len);
    end_rem = hdr_end ? removed : removed | !keep;
    end_len = hdr_end ? count : count + CW'(keep);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      pass_len <= '0;
      pass_pos <= '0;
      removed <= 1'b0;
      stalled <= 1'b0;
      opt <= '0;
    end else if ((state == ISSUE || state == WAIT_KEEP) && solved) begin
      state <= DONE;
      stalled <= 1'b0;
    end else if (pass_end) begin
      if (end_rem && end_len != '0) begin
        pass_len <= end_len;
        pass_pos <= '0;
        removed <= 1'b0;
        state <= ISSUE;
      end else begin
        state <= DONE;
        stalled <= 1'b1;
      end
    end else
      case (state)
        IDLE: if (load_valid) state <= LOAD;
        LOAD:
          if (load_done) begin
            // the first pass has no baseline, so it always counts as progress
            if (count == '0 && !push) begin
              state <= DONE;
              stalled <= 1'b1;
            end else begin
              pass_len <= count + CW'(push);
              pass_pos <= '0;
              removed <= 1'b1;
              state <= ISSUE;
            end
          end
        ISSUE:
          if (fire) begin
            pass_pos <= pos_n;
            if (!head[SIZE]) begin
              opt <= head[SIZE-1:0];
              state <= WAIT_KEEP;
            end
          end
        WAIT_KEEP:
          if (verdict) begin
            removed <= removed | !keep;
            state <= ISSUE;
          end
        default: state <= DONE;
      endcase
endmodule

// File: tb/tb_option_feeder.sv
// tb_option_feeder: randomized self-checking bench with a pass-level reference model.
module tb_option_feeder;
  logic clk = 0, rst_n = 0;
  logic load_valid = 0, load_hdr = 0, load_done = 0, out_ready = 0;
  logic keep_valid = 0, keep = 0, solved = 0;
  logic [2:0] load_data = 0;
  logic load_ready, out_valid, out_hdr, done, stalled;
  logic [2:0] out_data;
  logic [4:0] entries;
  int passed = 0, total = 0;

  option_feeder #(.SIZE(3), .DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_data(load_data),
    .load_hdr(load_hdr), .load_ready(load_ready), .load_done(load_done),
    .out_valid(out_valid), .out_data(out_data), .out_hdr(out_hdr), .out_ready(out_ready),
    .keep_valid(keep_valid), .keep(keep), .solved(solved), .done(done),
    .stalled(stalled), .entries(entries)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: run did not finish, passed=%0d total=%0d", passed, total);
    $fatal(1);
  end

  task automatic do_reset();
    {load_valid, load_hdr, load_done, out_ready, keep_valid, keep, solved} = '0;
    load_data = 0;
    rst_n = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic load_board(input logic [3:0] w[$], input bit go);
    int t;
    foreach (w[i]) begin
      load_valid = 1;
      {load_hdr, load_data} = w[i];
      t = 0;
      while (!load_ready && t < 10) begin @(negedge clk); t++; end
      @(negedge clk);
    end
    load_valid = 0;
    if (go) begin
      load_done = 1;
      @(negedge clk);
      load_done = 0;
    end
  endtask

  task automatic drive_word(input logic [3:0] exp, input bit k);
    int t = 0;
    while (!out_valid && t < 20) begin @(negedge clk); t++; end
    total++;
    if (!out_valid || {out_hdr, out_data} !== exp)
      $display("FAIL issue: got valid=%b word=%b, want valid=1 word=%b", out_valid, {out_hdr, out_data}, exp);
    else passed++;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    if (!exp[3]) begin
      total++;
      if (out_valid !== 1'b0) $display("FAIL wait_keep_valid: got %b want 0", out_valid);
      else passed++;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      keep_valid = 1;
      keep = k;
      @(negedge clk);
      keep_valid = 0;
    end
  endtask

  // mode 0: keep all, 1: drop word drop_idx of the first pass, 2: random verdicts
  task automatic run_board(input logic [3:0] words[$], input int mode, input int drop_idx);
    logic [3:0] cur[$], nxt[$];
    bit dropped, k;
    cur = words;
    for (int pass = 0; pass < 40; pass++) begin
      nxt = {};
      dropped = 0;
      foreach (cur[i]) begin
        k = mode == 0 ? 1'b1 : mode == 1 ? !(pass == 0 && i == drop_idx) : ($urandom_range(0, 3) != 0);
        drive_word(cur[i], k);
        if (cur[i][3] || k) nxt.push_back(cur[i]); else dropped = 1;
      end
      total++;
      if (entries !== 5'(nxt.size())) $display("FAIL pass_entries: got %0d want %0d", entries, nxt.size());
      else passed++;
      if ((!dropped && pass > 0) || nxt.size() == 0) break;
      cur = nxt;
    end
    total++;
    if ({done, stalled, out_valid} !== 3'b110)
      $display("FAIL stall_done: got done/stalled/valid=%b want 110", {done, stalled, out_valid});
    else passed++;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({load_ready, out_valid, out_hdr, out_data, done, stalled, entries} !== '0)
      $display("FAIL reset: got %b want all zero", {load_ready, out_valid, out_hdr, out_data, done, stalled, entries});
    else passed++;
  endtask

  task automatic test_keep_all();
    logic [3:0] w[$] = {4'b1000, 4'b0011, 4'b0110, 4'b1001, 4'b0101};
    do_reset();
    load_board(w, 1);
    total++;
    if (entries !== 5'd5) $display("FAIL keep_all_entries: got %0d want 5", entries);
    else passed++;
    run_board(w, 0, 0);
  endtask

  task automatic test_drop_one();
    logic [3:0] w[$] = {4'b1000, 4'b0011, 4'b0110, 4'b1001, 4'b0101};
    do_reset();
    load_board(w, 1);
    run_board(w, 1, 2);
  endtask

  task automatic test_empty_load();
    do_reset();
    load_valid = 1;
    @(negedge clk);
    load_valid = 0;
    load_done = 1;
    @(negedge clk);
    load_done = 0;
    total++;
    if ({done, stalled, entries} !== 7'b1100000)
      $display("FAIL empty_load: got done/stalled/entries=%b want 1100000", {done, stalled, entries});
    else passed++;
  endtask

  task automatic test_solved();
    logic [3:0] w[$] = {4'b1000, 4'b0011};
    int t = 0;
    do_reset();
    load_board(w, 1);
    drive_word(4'b1000, 1);
    while (!out_valid && t < 20) begin @(negedge clk); t++; end
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    solved = 1;
    keep_valid = 1;
    keep = 1;
    @(negedge clk);
    solved = 0;
    keep_valid = 0;
    total++;
    if ({done, stalled, out_valid, entries} !== 8'b10000001)
      $display("FAIL solved: got done/stalled/valid/entries=%b want 10000001", {done, stalled, out_valid, entries});
    else passed++;
    keep_valid = 1;
    repeat (3) @(negedge clk);
    keep_valid = 0;
    total++;
    if ({done, load_ready, entries} !== 7'b1000001)
      $display("FAIL done_sticky: got done/ready/entries=%b want 1000001", {done, load_ready, entries});
    else passed++;
  endtask

  task automatic test_full();
    logic [3:0] w[$];
    do_reset();
    w.push_back(4'b1000);
    for (int i = 1; i < 16; i++) w.push_back(4'($urandom_range(0, 15)));
    load_board(w, 0);
    load_valid = 1;
    {load_hdr, load_data} = 4'b0111;
    repeat (2) @(negedge clk);
    total++;
    if (load_ready !== 1'b0 || entries !== 5'd16)
      $display("FAIL full: got ready=%b entries=%0d want ready=0 entries=16", load_ready, entries);
    else passed++;
    load_valid = 0;
    load_done = 1;
    @(negedge clk);
    load_done = 0;
    run_board(w, 0, 0);
  endtask

  task automatic test_stall();
    logic [3:0] w[$] = {4'b1010, 4'b0110, 4'b0001};
    do_reset();
    load_board(w, 1);
    for (int i = 0; i < 10; i++) begin
      total++;
      if (!out_valid || {out_hdr, out_data} !== 4'b1010 || entries !== 5'd3)
        $display("FAIL hold: got valid=%b word=%b entries=%0d want 1 1010 3", out_valid, {out_hdr, out_data}, entries);
      else passed++;
      @(negedge clk);
    end
    run_board(w, 2, 0);
  endtask

  task automatic test_async_reset();
    logic [3:0] w[$] = {4'b1001, 4'b0100, 4'b0010};
    int t = 0;
    do_reset();
    load_board(w, 1);
    drive_word(4'b1001, 1);
    while (!out_valid && t < 20) begin @(negedge clk); t++; end
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    #2 rst_n = 0;
    #1;
    total++;
    if ({load_ready, out_valid, out_hdr, out_data, done, stalled, entries} !== '0)
      $display("FAIL async_reset: got %b want all zero", {load_ready, out_valid, out_hdr, out_data, done, stalled, entries});
    else passed++;
    @(negedge clk);
    rst_n = 1;
    keep_valid = 1;
    keep = 1;
    @(negedge clk);
    keep_valid = 0;
    total++;
    if ({entries, done, load_ready} !== '0)
      $display("FAIL stale_verdict: got entries/done/ready=%b want 0", {entries, done, load_ready});
    else passed++;
  endtask

  task automatic test_random();
    logic [3:0] w[$];
    for (int it = 0; it < 8; it++) begin
      w = {};
      for (int l = 0; l < int'($urandom_range(1, 3)); l++) begin
        w.push_back({1'b1, 3'(l)});
        repeat ($urandom_range(0, 3)) w.push_back({1'b0, 3'($urandom_range(0, 7))});
      end
      do_reset();
      load_board(w, 1);
      run_board(w, 2, 0);
    end
  endtask

  initial begin
    test_reset();
    test_keep_all();
    test_drop_one();
    test_empty_load();
    test_solved();
    test_full();
    test_stall();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
